// File: rtl/ddr_calib_monitor.sv
// DDR4 calibration monitor: per-channel calib_done synchronisers, calibration/loss FSM,
// saturating loss counters and a single-outstanding AXI4-Lite register slave.
module ddr_calib_lane (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       i_calib_done,
  input  logic       i_cnt_en,
  input  logic       i_clr,
  output logic       o_cd_s,
  output logic       o_fall,
  output logic [7:0] o_loss_cnt
);
  logic       r_meta, r_sync, r_prev;
  logic [7:0] r_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_cnt  <= 8'h00;
    end else begin
      r_meta <= i_calib_done;
      r_sync <= r_meta;
      r_prev <= r_sync;
      // clear takes priority, so a fall coinciding with it is dropped
      if (i_clr)                                   r_cnt <= 8'h00;
      else if (i_cnt_en && o_fall && r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_cd_s     = r_sync;
  assign o_fall     = r_prev & ~r_sync;
  assign o_loss_cnt = r_cnt;
endmodule

module ddr_calib_monitor #(
  parameter int          NUM_CH        = 4,
  parameter logic [31:0] CALIB_TIMEOUT = 32'd50_000_000,
  parameter logic [31:0] ID_VALUE      = 32'h5744_4D30
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [NUM_CH-1:0] calib_done,
  input  logic [11:0]       s_axil_awaddr,
  input  logic              s_axil_awvalid,
  output logic              s_axil_awready,
  input  logic [31:0]       s_axil_wdata,
  input  logic [3:0]        s_axil_wstrb,
  input  logic              s_axil_wvalid,
  output logic              s_axil_wready,
  output logic [1:0]        s_axil_bresp,
  output logic              s_axil_bvalid,
  input  logic              s_axil_bready,
  input  logic [11:0]       s_axil_araddr,
  input  logic              s_axil_arvalid,
  output logic              s_axil_arready,
  output logic [31:0]       s_axil_rdata,
  output logic [1:0]        s_axil_rresp,
  output logic              s_axil_rvalid,
  input  logic              s_axil_rready,
  output logic              ddr_ready,
  output logic              irq
);
  typedef enum logic [1:0] {
    S_WAIT    = 2'd0,
    S_READY   = 2'd1,
    S_TIMEOUT = 2'd2,
    S_LOST    = 2'd3
  } state_t;

  localparam logic [9:0] A_ID      = 10'h000;
  localparam logic [9:0] A_STATUS  = 10'h001;
  localparam logic [9:0] A_CYCLES  = 10'h002;
  localparam logic [9:0] A_LOSS_LO = 10'h003;
  localparam logic [9:0] A_CTRL    = 10'h004;
  localparam logic [9:0] A_SCRATCH = 10'h005;
  localparam logic [9:0] A_LOSS_HI = 10'h007;

  state_t            r_state, w_state_nxt;
  logic [31:0]       r_calib_cycles;
  logic [NUM_CH-1:0] w_cd_s, w_fall;
  logic [7:0][7:0]   w_loss;
  logic              w_all_done, w_cnt_en, w_clr;
  logic              r_irq, r_irq_en;
  logic [31:0]       r_scratch;
  logic              r_wr_acc, r_bvalid;
  logic              r_arready, r_rvalid;
  logic [31:0]       r_rdata, w_rd_data, w_status;
  logic [9:0]        w_waddr, w_raddr;
  logic              w_unused;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    if (gi < NUM_CH) begin : g_on
      ddr_calib_lane u_lane (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_calib_done(calib_done[gi]),
        .i_cnt_en    (w_cnt_en),
        .i_clr       (w_clr),
        .o_cd_s      (w_cd_s[gi]),
        .o_fall      (w_fall[gi]),
        .o_loss_cnt  (w_loss[gi])
      );
    end else begin : g_off
      assign w_loss[gi] = 8'h00;
    end
  end

  assign w_all_done = &w_cd_s;
  assign w_cnt_en   = (r_state == S_READY) || (r_state == S_LOST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_WAIT;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT: begin
        if (w_all_done)                                     w_state_nxt = S_READY;
        else if (r_calib_cycles == CALIB_TIMEOUT - 32'd1)   w_state_nxt = S_TIMEOUT;
      end
      S_TIMEOUT, S_LOST: if (w_all_done) w_state_nxt = S_READY;
      S_READY:           if (|w_fall)    w_state_nxt = S_LOST;
      default:           w_state_nxt = S_WAIT;
    endcase
  end

  // counting stops on the edge that enters READY, so the value is the time spent calibrating
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_calib_cycles <= 32'd0;
      r_irq          <= 1'b0;
    end else begin
      if ((r_state == S_WAIT || r_state == S_TIMEOUT) && !w_all_done &&
          r_calib_cycles != 32'hFFFF_FFFF)
        r_calib_cycles <= r_calib_cycles + 32'd1;
      r_irq <= r_irq_en && (r_state == S_TIMEOUT || r_state == S_LOST);
    end
  end

  assign w_waddr = s_axil_awaddr[11:2];
  assign w_raddr = s_axil_araddr[11:2];
  assign w_clr   = r_wr_acc && w_waddr == A_CTRL && s_axil_wstrb[0] && s_axil_wdata[1];

  // write: accept AW+W together, commit on the handshake edge, hold B until taken
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wr_acc  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_irq_en  <= 1'b0;
      r_scratch <= 32'd0;
    end else begin
      r_wr_acc <= s_axil_awvalid && s_axil_wvalid && !r_bvalid && !r_wr_acc;
      if (r_wr_acc) begin
        r_bvalid <= 1'b1;
        if (w_waddr == A_CTRL && s_axil_wstrb[0]) r_irq_en <= s_axil_wdata[0];
        if (w_waddr == A_SCRATCH)
          for (int b = 0; b < 4; b++)
            if (s_axil_wstrb[b]) r_scratch[8*b +: 8] <= s_axil_wdata[8*b +: 8];
      end else if (r_bvalid && s_axil_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_comb begin
    w_status        = 32'd0;
    w_status[NUM_CH-1:0] = w_cd_s;
    w_status[8]     = w_all_done;
    w_status[9]     = (r_state == S_TIMEOUT);
    w_status[10]    = (r_state == S_LOST);
    w_status[13:12] = r_state;
  end

  always_comb begin
    w_rd_data = 32'd0;
    case (w_raddr)
      A_ID:      w_rd_data = ID_VALUE;
      A_STATUS:  w_rd_data = w_status;
      A_CYCLES:  w_rd_data = r_calib_cycles;
      A_LOSS_LO: w_rd_data = w_loss[3:0];
      A_CTRL:    w_rd_data = {31'd0, r_irq_en};
      A_SCRATCH: w_rd_data = r_scratch;
      A_LOSS_HI: w_rd_data = w_loss[7:4];
      default:   w_rd_data = 32'd0;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_arready <= s_axil_arvalid && !r_rvalid && !r_arready;
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
      end else if (r_rvalid && s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axil_awready = r_wr_acc;
  assign s_axil_wready  = r_wr_acc;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = 2'b00;
  assign ddr_ready      = (r_state == S_READY);
  assign irq            = r_irq;
  assign w_unused       = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};
endmodule
